reg_bank: RTL and testbench
===========================

Name: reg_bank

Overview:
- 32 x 32-bit general-purpose register file for the multicycle MIPS datapath.
- Sink of the write-destination index produced by the RegDst selection logic (rt, rd, rs, $ra=31, $sp=29).
- One synchronous write port and two combinational read ports, feeding the A/B operand registers.
- Handles reset initialisation of $sp, hard-wired $zero, and an optional same-cycle write-to-read bypass.

Parameters:
- SP_INIT, 32'd227: reset value of register 29 ($sp).
- RA_INIT, 32'd0: reset value of register 31 ($ra).
- BYPASS, 1: 1 = a read port addressing the register being written this cycle returns WriteData; 0 = it returns the stored (old) value.

Ports:
- clk  input  1  rising-edge clock; only clock of the block.
- reset_n  input  1  synchronous, active-low reset.
- RegWrite  input  1  write enable, sampled on the rising edge of clk.
- WriteReg  input  5  write index; output of the RegDst mux.
- WriteData  input  32  data written to WriteReg.
- ReadReg1  input  5  read index, port 1 (rs).
- ReadReg2  input  5  read index, port 2 (rt).
- ReadData1  output  32  contents of ReadReg1, combinational.
- ReadData2  output  32  contents of ReadReg2, combinational.

Behaviour:
- Storage: registers r1..r31 are flops. r0 is not stored.
- Reset: on a rising edge with reset_n=0, all of r1..r31 load 0, except r29 = SP_INIT and r31 = RA_INIT.
- Reset has priority over writes: RegWrite is ignored on any edge where reset_n=0.
- Reset mid-program: state is reinitialised on that edge. No partial write occurs.
- Reset is synchronous only: asserting reset_n=0 between edges changes nothing until the next rising edge.
- Write: on a rising edge with reset_n=1 and RegWrite=1, r[WriteReg] <= WriteData. The new value is visible at ReadDataX from the following cycle. Latency is 1 clk.
- Write with RegWrite=0: no register changes. WriteReg and WriteData are don't-care.
- r0: reads always return 32'd0. Writes to index 0 are discarded silently with no side effects, including under bypass.
- Read: ReadDataX = r[ReadRegX]. Purely combinational from ReadRegX and the stored state. Zero-cycle latency. No clock enable.
- Bypass (BYPASS=1), applied per port independently:
  - If RegWrite=1, reset_n=1, WriteReg==ReadRegX and WriteReg!=0, then ReadDataX = WriteData in the same cycle.
  - Both ports may bypass simultaneously when ReadReg1==ReadReg2==WriteReg.
- BYPASS=0: the read returns the pre-edge value until the edge, then the new value.
- Read during reset_n=0: ports return the current stored contents. Bypass is suppressed.
- Both read ports may address the same register. There are no port conflicts.
- Indices 29 and 31 are ordinary registers after reset: fully writable, no special write behaviour.
- No X propagation: every register has a defined value after the first reset edge. Before the first reset, contents are unspecified.
- Widths: indices are exactly 5 bits, so there are no out-of-range cases. Data is 32 bits and is never truncated or extended.

Test Plan:
1. Hold reset_n=0 for 1 edge, then read all 32 indices over both ports -> r29=227, r31=0, all others 0. Also check an edge with reset_n=0 and RegWrite=1, WriteReg=5, WriteData=32'hDEAD -> r5 stays 0.
2. Write 32'h12345678 to r8, then 32'hFFFFFFFF to r31. Read ReadReg1=8, ReadReg2=31 the next cycle -> 32'h12345678 and 32'hFFFFFFFF.
3. RegWrite=1, WriteReg=0, WriteData=32'hCAFEBABE, with ReadReg1=ReadReg2=0 in the same cycle and the next -> both ports read 0 in both cycles (BYPASS=1 and BYPASS=0 builds).
4. With r9=32'h1, write WriteReg=9, WriteData=32'h2 while ReadReg1=ReadReg2=9:
   - BYPASS=1 -> both ports read 32'h2 in the write cycle.
   - BYPASS=0 -> both ports read 32'h1 in the write cycle, then 32'h2 after the edge.
5. Write r29=32'h100, then drive reset_n=0 between edges without an edge -> r29 stays 32'h100. After the next rising edge -> r29 = 227.
6. Back-to-back writes on consecutive edges to r4 (32'hA), r4 (32'hB), r5 (32'hC), with RegWrite=0 on the 4th edge carrying WriteData=32'hD -> r4=32'hB, r5=32'hC, and no register holds 32'hD.

Source files
------------

// File: rtl/reg_bank.sv
// reg_bank: 32 x 32-bit general-purpose register file for the multicycle
// MIPS datapath. It has one synchronous write port and two combinational
// read ports.
//
// Parameters
//   SP_INIT   reset value of r29 ($sp)
//   RA_INIT   reset value of r31 ($ra)
//   BYPASS    1: a read of the register being written this cycle returns
//                WriteData in the same cycle.
//             0: such a read returns the stored value until the edge.
//
// Ports
//   clk        rising-edge clock
//   reset_n    synchronous active-low reset; has priority over writes
//   RegWrite   write enable
//   WriteReg   write index (from the RegDst mux)
//   WriteData  write data
//   ReadReg1   read index, port 1 (rs)
//   ReadReg2   read index, port 2 (rt)
//   ReadData1  r[ReadReg1], combinational
//   ReadData2  r[ReadReg2], combinational

// One read port. r0 is already zero in rf_view. byp_en is only true for a
// live, non-reset write to a nonzero index, so r0 can never be bypassed.
module reg_bank_rd_port #(
    parameter bit BYPASS = 1'b1
) (
    input  logic [4:0]        rd_idx,
    input  logic [31:0][31:0] rf_view,
    input  logic              byp_en,
    input  logic [4:0]        wr_idx,
    input  logic [31:0]       wr_data,
    output logic [31:0]       rd_data
);
    always_comb begin
        rd_data = rf_view[rd_idx];
        if (BYPASS && byp_en && (rd_idx == wr_idx))
            rd_data = wr_data;
    end
endmodule

module reg_bank #(
    parameter logic [31:0] SP_INIT = 32'd227,
    parameter logic [31:0] RA_INIT = 32'd0,
    parameter bit          BYPASS  = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        RegWrite,
    input  logic [4:0]  WriteReg,
    input  logic [31:0] WriteData,
    input  logic [4:0]  ReadReg1,
    input  logic [4:0]  ReadReg2,
    output logic [31:0] ReadData1,
    output logic [31:0] ReadData2
);
    localparam int NUM_RD = 2;

    // Only r1..r31 are stored. r0 is a constant zero.
    logic [31:1][31:0]       rf;
    logic [31:0][31:0]       rf_view;
    logic                    byp_en;
    logic [NUM_RD-1:0][4:0]  rd_idx;
    logic [NUM_RD-1:0][31:0] rd_data;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 1; i < 32; i++) begin
                if (i == 29)
                    rf[i] <= SP_INIT;
                else if (i == 31)
                    rf[i] <= RA_INIT;
                else
                    rf[i] <= 32'd0;
            end
        end else if (RegWrite && (WriteReg != 5'd0)) begin
            rf[WriteReg] <= WriteData;
        end
    end

    assign rf_view = {rf, 32'd0};

    // A bypass is only allowed for a write that will actually commit on
    // this edge. While reset is held, reads return the stored contents.
    assign byp_en = reset_n & RegWrite & (WriteReg != 5'd0);

    assign rd_idx    = {ReadReg2, ReadReg1};
    assign ReadData1 = rd_data[0];
    assign ReadData2 = rd_data[1];

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        reg_bank_rd_port #(.BYPASS(BYPASS)) u_rd (
            .rd_idx  (rd_idx[p]),
            .rf_view (rf_view),
            .byp_en  (byp_en),
            .wr_idx  (WriteReg),
            .wr_data (WriteData),
            .rd_data (rd_data[p])
        );
    end
endmodule

// File: tb/tb_reg_bank.sv
module tb_reg_bank;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [4:0]  ReadReg1, ReadReg2;
    logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;

    always #5 clk = ~clk;

    reg_bank #(.BYPASS(1'b1)) u_byp (
        .clk(clk), .reset_n(reset_n), .RegWrite(RegWrite), .WriteReg(WriteReg),
        .WriteData(WriteData), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .ReadData1(rd1_b), .ReadData2(rd2_b)
    );

    reg_bank #(.BYPASS(1'b0)) u_nbyp (
        .clk(clk), .reset_n(reset_n), .RegWrite(RegWrite), .WriteReg(WriteReg),
        .WriteData(WriteData), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .ReadData1(rd1_n), .ReadData2(rd2_n)
    );

    // Expected read data for one cycle. e* is for the bypass build and n*
    // is for the non-bypass build.
    typedef struct {
        string       tag;
        logic [31:0] e1, e2, n1, n2;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic cmp(input string tag, input string port,
                       input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s %s: got %h expected %h", tag, port, act, exp);
        end
    endtask

    // The monitor samples on the falling edge, mid-cycle. Each cycle's
    // inputs were applied just after the preceding rising edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_vec++;
            cmp(e.tag, "byp.rd1",  rd1_b, e.e1);
            cmp(e.tag, "byp.rd2",  rd2_b, e.e2);
            cmp(e.tag, "nbyp.rd1", rd1_n, e.n1);
            cmp(e.tag, "nbyp.rd2", rd2_n, e.n2);
        end
    end

    task automatic drive(input string tag, input logic rst_n, input logic we,
                         input logic [4:0] wreg, input logic [31:0] wdata,
                         input logic [4:0] r1, input logic [4:0] r2,
                         input logic [31:0] e1, input logic [31:0] e2,
                         input logic [31:0] n1, input logic [31:0] n2);
        exp_t e;
        @(posedge clk);
        #1;
        reset_n   = rst_n;
        RegWrite  = we;
        WriteReg  = wreg;
        WriteData = wdata;
        ReadReg1  = r1;
        ReadReg2  = r2;
        e.tag = tag; e.e1 = e1; e.e2 = e2; e.n1 = n1; e.n2 = n2;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] after_reset(input int i);
        return (i == 29) ? 32'd227 : 32'd0;
    endfunction

    function automatic logic [31:0] after_b2b(input int i);
        case (i)
            4:       return 32'hB;
            5:       return 32'hC;
            29:      return 32'd227;
            default: return 32'd0;
        endcase
    endfunction

    initial begin
        // Reset is held from time 0, so the first edge initialises the file.
        reset_n = 1'b0; RegWrite = 1'b0; WriteReg = '0; WriteData = '0;
        ReadReg1 = '0; ReadReg2 = '0;

        // Reset has priority: the write of DEAD to r5 must be dropped, and
        // bypass is suppressed while reset is low.
        drive("rst_wr",   1'b0, 1'b1, 5'd5, 32'hDEAD, 5'd5, 5'd29, 0, 227, 0, 227);
        drive("rst_r5",   1'b1, 1'b0, 5'd0, 32'h0,    5'd5, 5'd31, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++)
            drive($sformatf("rst_scan%0d", i), 1'b1, 1'b0, 5'd0, 32'h0,
                  5'(i), 5'(i + 16), after_reset(i), after_reset(i + 16),
                  after_reset(i), after_reset(i + 16));

        // Plain writes to r8 and r31.
        drive("wr8",   1'b1, 1'b1, 5'd8,  32'h12345678, 5'd8, 5'd31,
              32'h12345678, 0, 0, 0);
        drive("wr31",  1'b1, 1'b1, 5'd31, 32'hFFFFFFFF, 5'd8, 5'd31,
              32'h12345678, 32'hFFFFFFFF, 32'h12345678, 0);
        drive("rd8_31", 1'b1, 1'b0, 5'd0, 32'h0, 5'd8, 5'd31,
              32'h12345678, 32'hFFFFFFFF, 32'h12345678, 32'hFFFFFFFF);

        // r0 stays zero, even under bypass.
        drive("wr0",  1'b1, 1'b1, 5'd0, 32'hCAFEBABE, 5'd0, 5'd0, 0, 0, 0, 0);
        drive("rd0",  1'b1, 1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 0, 0, 0, 0);

        // Same-cycle write/read of r9 on both ports.
        drive("r9_1",  1'b1, 1'b1, 5'd9, 32'h1, 5'd9, 5'd9, 1, 1, 0, 0);
        drive("r9_2",  1'b1, 1'b1, 5'd9, 32'h2, 5'd9, 5'd9, 2, 2, 1, 1);
        drive("r9_rd", 1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 2, 2, 2, 2);

        // A reset_n drop between edges changes nothing until the edge.
        drive("sp_wr",  1'b1, 1'b1, 5'd29, 32'h100, 5'd29, 5'd29,
              32'h100, 32'h100, 227, 227);
        drive("sp_mid", 1'b0, 1'b1, 5'd29, 32'h55, 5'd29, 5'd29,
              32'h100, 32'h100, 32'h100, 32'h100);
        drive("sp_rst", 1'b1, 1'b0, 5'd0, 32'h0, 5'd29, 5'd8, 227, 0, 227, 0);

        // Back-to-back writes, followed by a disabled write carrying D.
        drive("b2b_a",  1'b1, 1'b1, 5'd4, 32'hA, 5'd4, 5'd5, 32'hA, 0, 0, 0);
        drive("b2b_b",  1'b1, 1'b1, 5'd4, 32'hB, 5'd4, 5'd5, 32'hB, 0, 32'hA, 0);
        drive("b2b_c",  1'b1, 1'b1, 5'd5, 32'hC, 5'd4, 5'd5, 32'hB, 32'hC, 32'hB, 0);
        drive("b2b_d",  1'b1, 1'b0, 5'd5, 32'hD, 5'd4, 5'd5, 32'hB, 32'hC, 32'hB, 32'hC);
        for (int i = 0; i < 16; i++)
            drive($sformatf("b2b_scan%0d", i), 1'b1, 1'b0, 5'd0, 32'h0,
                  5'(i), 5'(i + 16), after_b2b(i), after_b2b(i + 16),
                  after_b2b(i), after_b2b(i + 16));

        // Let the monitor drain the queue, within a bounded number of cycles.
        for (int k = 0; k < 20 && sb.size() > 0; k++)
            @(posedge clk);
        if (sb.size() > 0) begin
            n_miss++;
            $display("FAIL drain: %0d vectors left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
